// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial sequencer driving an external 1-bit ALU slice
//
// Purpose: latches an N-bit operation (NOR/XOR/ADD/SUB), feeds it LSB first
// to an external 1-bit slice over N cycles, and reassembles the result.
// Optional feature macro: SERIAL_ALU_OVF_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a_in,    operation request (accepted in IDLE or DONE),
//   b_in                opcode (00 NOR, 01 XOR, 10 ADD, 11 SUB) and operands
//   busy, done          operation in progress / one-cycle completion pulse
//   result, cout_out    final word and carry, held until the next completion
//   alu_a, alu_b,       current bit pair, carry-in and opcode to the slice
//   alu_cin, alu_op
//   alu_s, alu_cout     slice sum and carry outputs
//   ovf                 (SERIAL_ALU_OVF_EN only) signed overflow for ADD/SUB

module serial_alu_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         cout_out,
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_cin,
    output logic [1:0]   alu_op,
    input  logic         alu_s,
    input  logic         alu_cout
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [1:0]    op_q, op_d;
    logic          cout_q, cout_d;
`ifdef SERIAL_ALU_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        cout_d  = cout_q;
`ifdef SERIAL_ALU_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    op_d    = op;
                    cnt_d   = '0;
                    // SUB is A + ~B + 1: the +1 enters as the initial carry.
                    carry_d = (op == 2'b11);
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                sh_d    = N'({alu_s, sh_q} >> 1);
                carry_d = alu_cout;
                if (cnt_q == LAST) begin
                    // Counter holds here so it never wraps for power-of-two N.
                    res_d   = N'({alu_s, sh_q} >> 1);
                    cout_d  = op_q[1] & alu_cout;
`ifdef SERIAL_ALU_OVF_EN
                    // Carry into vs. out of the MSB differ on signed overflow.
                    ovf_d   = op_q[1] & (carry_q ^ alu_cout);
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 2'b00;
            cout_q  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ALU_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = res_q;
    assign cout_out = cout_q;
    assign alu_a    = a_q[0];
    assign alu_b    = b_q[0];
    assign alu_cin  = carry_q;
    assign alu_op   = op_q;
`ifdef SERIAL_ALU_OVF_EN
    assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb/tb_serial_alu_ctrl.sv - self-checking bench for serial_alu_ctrl

module tb_serial_alu_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
    logic         busy, done, cout_out;
    logic [N-1:0] result;
    logic         alu_a, alu_b, alu_cin, alu_s, alu_cout;
    logic [1:0]   alu_op;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .cout_out(cout_out),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_cout(alu_cout)
`ifdef SERIAL_ALU_OVF_EN
        , .ovf(ovf)
`endif
    );

    // External 1-bit slice: inverts B itself for SUB.
    logic slice_b;
    always_comb begin
        slice_b  = (alu_op == 2'b11) ? ~alu_b : alu_b;
        alu_s    = 1'b0;
        alu_cout = 1'b0;
        case (alu_op)
            2'b00: begin alu_s = ~(alu_a | alu_b); alu_cout = alu_a & alu_b; end
            2'b01: begin alu_s = alu_a ^ alu_b;    alu_cout = alu_a & alu_b; end
            default: begin
                alu_s    = alu_a ^ slice_b ^ alu_cin;
                alu_cout = (alu_a & slice_b) | (alu_cin & (alu_a ^ slice_b));
            end
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Word-level reference: {carry, result}.
    function automatic logic [N:0] ref_calc(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        case (o)
            2'b00:   return {1'b0, ~(a | b)};
            2'b01:   return {1'b0, a ^ b};
            2'b10:   return {1'b0, a} + {1'b0, b};
            default: return {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] r);
        if (!o[1]) return 1'b0;
        if (o == 2'b10) return (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        return (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
    endfunction

    // Carry into bit i = bit i of the sum of the low i bits.
    function automatic logic cin_at(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b, input int i);
        logic [N:0] one, mask, s;
        one  = 1;
        mask = (one << i) - one;
        if (o == 2'b11) s = ({1'b0, a} & mask) + ({1'b0, ~b} & mask) + one;
        else            s = ({1'b0, a} & mask) + ({1'b0, b} & mask);
        return s[i];
    endfunction

    // Behavioural model: cycles remaining of the current operation plus held outputs.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [N-1:0] m_a = '0, m_b = '0, m_res = '0, p_res = '0;
    logic [1:0]   m_op = 2'b00;
    logic         m_cout = 1'b0, p_cout = 1'b0, m_ovf = 1'b0, p_ovf = 1'b0;
    logic [N:0]   m_r;
    bit           m_acc;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_left = 0; m_done = 1'b0; m_a = '0; m_b = '0; m_res = '0;
            m_op = 2'b00; m_cout = 1'b0; m_ovf = 1'b0;
        end else begin
            m_acc  = start && (m_left == 0);
            m_done = (m_left == 1);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
                end
            end
            if (m_acc) begin
                m_a = a_in; m_b = b_in; m_op = op;
                m_r = ref_calc(op, a_in, b_in);
                p_res  = m_r[N-1:0];
                p_cout = m_r[N];
                p_ovf  = ref_ovf(op, a_in, b_in, m_r[N-1:0]);
                m_left = N;
            end
        end
    end

    // Compare process: every falling edge.
    initial forever begin
        @(negedge clk);
        if (done) done_count++;
        chk("busy", busy, m_left > 0);
        chk("done", done, m_done);
        chk("result", result, m_res);
        chk("cout_out", cout_out, m_cout);
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, (m_left > 0) ? m_a[N-m_left] : 1'b0);
        chk("alu_b", alu_b, (m_left > 0) ? m_b[N-m_left] : 1'b0);
        if (m_left > 0 && m_op[1])
            chk("alu_cin", alu_cin, cin_at(m_op, m_a, m_b, N - m_left));
        if (!rst_n)
            chk("alu_cin_rst", alu_cin, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b1; op = o; a_in = a; b_in = b;
        step();
        start = 1'b0; op = 2'($urandom); a_in = N'($urandom); b_in = N'($urandom);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < N + 6) begin
            step();
            k++;
        end
        if (!done) chk("done_timeout", done, 1'b1);
    endtask

    task automatic run_lit(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] er, input logic ec);
        int k;
        issue(o, a, b);
        wait_done(k);
        chk("latency", k, N);
        chk("lit_result", result, er);
        chk("lit_cout", cout_out, ec);
    endtask

    int dc0;
    int hold;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 0);
        chk("rst_alu_op", alu_op, 2'b00);

        run_lit(2'b10, 8'h5A, 8'h3C, 8'h96, 1'b0);
        step();
        run_lit(2'b10, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_lit(2'b11, 8'h00, 8'h01, 8'hFF, 1'b0);
        step();
        run_lit(2'b11, 8'h10, 8'h01, 8'h0F, 1'b1);
        run_lit(2'b00, 8'hF0, 8'h0F, 8'h00, 1'b0);
        run_lit(2'b01, 8'hAA, 8'hFF, 8'h55, 1'b0);
        step();

        // start during RUN must be ignored
        dc0 = done_count;
        issue(2'b10, 8'h01, 8'h01);
        step(); step();
        start = 1'b1; op = 2'b00; a_in = 8'hFF; b_in = 8'hFF;
        step();
        start = 1'b0;
        begin
            int k;
            wait_done(k);
        end
        chk("ign_result", result, 8'h02);
        chk("ign_cout", cout_out, 1'b0);
        step(); step();
        chk("one_done", done_count - dc0, 1);

        // reset in the middle of RUN
        dc0 = done_count;
        issue(2'b10, 8'h0F, 8'h01);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_result", result, 0);
        chk("arst_alu", {alu_a, alu_b, alu_cin, alu_op}, 0);
        step();
        rst_n = 1'b1;
        repeat (N + 2) step();
        chk("arst_no_done", done_count - dc0, 0);
        run_lit(2'b10, 8'h03, 8'h04, 8'h07, 1'b0);
        step();

`ifdef SERIAL_ALU_OVF_EN
        run_lit(2'b10, 8'h7F, 8'h01, 8'h80, 1'b0);
        chk("ovf_add", ovf, 1'b1);
        run_lit(2'b11, 8'h80, 8'h01, 8'h7F, 1'b1);
        chk("ovf_sub", ovf, 1'b1);
        run_lit(2'b10, 8'h01, 8'h01, 8'h02, 1'b0);
        chk("ovf_none", ovf, 1'b0);
        step();
`endif

        // randomized traffic, including back-to-back and held starts
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 3)) step();
            hold = $urandom_range(1, N + 2);
            for (int h = 0; h < hold; h++) begin
                start = 1'b1;
                op    = 2'($urandom);
                a_in  = N'($urandom);
                b_in  = N'($urandom);
                step();
            end
            start = 1'b0;
        end
        repeat (N + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
